pim_dot_sequencer: RTL and testbench
====================================

# pim_dot_sequencer

Upstream control stage for the PIM multiply-accumulate unit. On `start`, it streams two operand vectors out of a pair of local synchronous-read memory banks. It drives the MAC's `a`/`b`/`clear`/`next` inputs with `next` aligned to the MAC's two-stage pipeline, then captures the 65-bit `psum` as the dot-product result. It sits between the PIM command decoder and the MAC and owns all MAC sequencing.

## Interface
Parameters:
- `ADDR_W`, default 8: bank address width. Vector length is 0..2^ADDR_W.
- `DATA_W`, default 32: operand width. Must equal the MAC operand width.

Ports:
- `clk`  in  1  clock
- `reset_n`  in  1  synchronous, active-low reset
- `start`  in  1  command strobe; sampled only in IDLE
- `base_a`, `base_b`  in  ADDR_W  first address in bank A / bank B
- `len`  in  ADDR_W+1  number of element pairs
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse; `result` is valid from this cycle
- `result`  out  65  last dot product; held until the next `done`
- `rd_en_a`, `rd_en_b`  out  1  bank read enables; read latency is 1 cycle
- `rd_addr_a`, `rd_addr_b`  out  ADDR_W  bank read addresses
- `rd_data_a`, `rd_data_b`  in  DATA_W  bank read data
- `mac_a`, `mac_b`  out  DATA_W  combinational pass-through of `rd_data_a` / `rd_data_b`
- `mac_clear`, `mac_next`  out  1  MAC controls
- `mac_psum`  in  65  MAC accumulator output

## Operation
State machine: IDLE → CLEAR → ISSUE → DRAIN → DONE → IDLE.
- **IDLE**
  - `start` with `len` != 0: latch the bases and `len`, go to CLEAR.
  - `start` with `len` == 0: `result` <= 0, pulse `done` next cycle, stay in IDLE, no reads.
- **CLEAR** (1 cycle): `mac_clear` = 1. Go to ISSUE.
- **ISSUE** (`len` cycles): `rd_en_a` = `rd_en_b` = 1.
  - Both addresses increment by 1 per cycle, modulo 2^ADDR_W (wraps 255 → 0 for ADDR_W = 8).
  - Leave after the `len`-th read.
- **DRAIN** (3 cycles): no reads. Waits for the valid pipeline to empty.
- **DONE** (1 cycle): `result` <= `mac_psum`. Next cycle `done` = 1 and the state is IDLE.
- Valid pipeline: `rd_en_a` is delayed by 3 cycles (1 memory cycle + 2 MAC cycles) and drives `mac_next`. `mac_next` is therefore high exactly `len` cycles.
- `start` while `busy` is ignored. No queuing, no error.
- Arithmetic: the MAC accumulates unsigned values mod 2^65. This block performs no arithmetic except the overflow compare (see Configuration).
- Reset (including mid-operation): state IDLE; `busy`, `done`, `rd_en_*`, `mac_clear`, `mac_next` = 0; `rd_addr_*` = 0; `result` = 0; valid pipeline flushed. The MAC shares `reset_n`.

## Timing
Let `start` be accepted in cycle s, with N = `len` ≥ 1.
- `mac_clear` is high in cycle s+1.
- `rd_en` is high in cycles s+2 .. s+N+1.
- `mac_next` is high in cycles s+5 .. s+N+4.
- DONE is cycle s+N+5.
- `done` and the new `result` appear in cycle s+N+6. `busy` falls in the same cycle.
- For N = 0, `done` is high in cycle s+1.
- A new `start` is accepted in the `done` cycle.

## Configuration
- `PIM_DOT_OVF_EN` defined:
  - Adds output `ovf` (1 bit).
  - A sticky flag, cleared in CLEAR, is set when `mac_psum` is less than its registered previous value in any cycle after a `mac_next` cycle. This indicates 65-bit wrap.
  - `ovf` is registered with `result` and valid with `done`. Reset value is 0.
- `PIM_DOT_OVF_EN` undefined: no `ovf` port and no comparator logic.

## Structure
- Package `pim_dot_pkg` contains:
  - the state enum
  - `MEM_LAT` = 1, `MAC_LAT` = 2
  - `NEXT_DLY` = `MEM_LAT` + `MAC_LAT`
  - `PSUM_W` = 65
- Sub-module `pim_valid_delay`: a parameterised-depth shift register of 1-bit valids, depth `NEXT_DLY`, with synchronous flush.

## Test plan
- **Basic dot product:** `len` = 4, A = {1,2,3,4}, B = {5,6,7,8}, start in cycle s → `result` = 70, `done` in s+10, `mac_next` high only in s+5..s+8.
- **Zero length:** `len` = 0 → `done` in s+1, `result` = 0, no `rd_en`, no `mac_clear`.
- **Back-to-back:**
  - A second `start` while busy is ignored.
  - A `start` in the `done` cycle runs the next command: `len` = 2, A = {3,3}, B = {2,2} → `result` = 12. This proves the clear is effective.
- **Address wrap:** `base_a` = 254, `base_b` = 0, `len` = 4 → `rd_addr_a` = 254,255,0,1 and `rd_addr_b` = 0,1,2,3.
- **Overflow:** A = B = 0xFFFFFFFF, `len` = 3 → `result` = 0x0_FFFF_FFFA_0000_0003; `ovf` = 1 when the macro is defined.
- **Reset mid-operation:** `reset_n` low in the 2nd ISSUE cycle → all outputs 0 the next cycle. A later `len` = 1, A = {7}, B = {9} command gives `result` = 63.

Source files
------------

// File: rtl/pim_dot_pkg.sv
// Shared constants and FSM state encoding for the PIM dot-product sequencer.
// The sequencer latency figures below are coupled to the MAC pipeline depth.
package pim_dot_pkg;

    localparam int MEM_LAT  = 1;
    localparam int MAC_LAT  = 2;
    localparam int NEXT_DLY = MEM_LAT + MAC_LAT;
    localparam int PSUM_W   = 65;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_ISSUE = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/pim_valid_delay.sv
// Fixed-depth shift register for 1-bit valid flags with a synchronous flush.
// Used to line up the read strobe with the MAC's accumulate slot.
module pim_valid_delay #(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic i_flush,
    input  logic i_valid,
    output logic o_valid
);

    logic r_pipe [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (i_flush) r_pipe[gi] <= 1'b0;
                    else         r_pipe[gi] <= i_valid;
                end
            end else begin : g_tail
                always_ff @(posedge clk) begin
                    if (i_flush) r_pipe[gi] <= 1'b0;
                    else         r_pipe[gi] <= r_pipe[gi-1];
                end
            end
        end
    endgenerate

    assign o_valid = r_pipe[DEPTH-1];

endmodule

// File: rtl/pim_dot_sequencer.sv
// Streams two operand vectors from local banks into the MAC and captures the dot product.
// Optional build macro PIM_DOT_OVF_EN adds a sticky 65-bit wrap flag on port ovf.
module pim_dot_sequencer
    import pim_dot_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_a,
    input  logic [ADDR_W-1:0]   base_b,
    input  logic [ADDR_W:0]     len,
    output logic                busy,
    output logic                done,
    output logic [PSUM_W-1:0]   result,
    output logic                rd_en_a,
    output logic                rd_en_b,
    output logic [ADDR_W-1:0]   rd_addr_a,
    output logic [ADDR_W-1:0]   rd_addr_b,
    input  logic [DATA_W-1:0]   rd_data_a,
    input  logic [DATA_W-1:0]   rd_data_b,
    output logic [DATA_W-1:0]   mac_a,
    output logic [DATA_W-1:0]   mac_b,
    output logic                mac_clear,
    output logic                mac_next,
    input  logic [PSUM_W-1:0]   mac_psum
`ifdef PIM_DOT_OVF_EN
    ,
    output logic                ovf
`endif
);

    state_e              r_state;
    logic [ADDR_W-1:0]   r_addr_a;
    logic [ADDR_W-1:0]   r_addr_b;
    logic [ADDR_W:0]     r_remain;
    logic [1:0]          r_drain;
    logic                r_done;
    logic [PSUM_W-1:0]   r_result;
    logic                w_issue;
    logic                w_flush;
    logic                w_zero_cmd;

    assign w_issue    = (r_state == ST_ISSUE);
    assign w_flush    = !reset_n;
    assign w_zero_cmd = (r_state == ST_IDLE) && start && (len == '0);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_addr_a <= '0;
            r_addr_b <= '0;
            r_remain <= '0;
            r_drain  <= '0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (len == '0) begin
                            r_result <= '0;
                            r_done   <= 1'b1;
                        end else begin
                            r_addr_a <= base_a;
                            r_addr_b <= base_b;
                            r_remain <= len;
                            r_state  <= ST_CLEAR;
                        end
                    end
                end
                ST_CLEAR: r_state <= ST_ISSUE;
                ST_ISSUE: begin
                    // Addresses wrap naturally at the bank size.
                    r_addr_a <= r_addr_a + ADDR_W'(1);
                    r_addr_b <= r_addr_b + ADDR_W'(1);
                    r_remain <= r_remain - (ADDR_W+1)'(1);
                    if (r_remain == (ADDR_W+1)'(1)) begin
                        r_state <= ST_DRAIN;
                        r_drain <= 2'(NEXT_DLY - 1);
                    end
                end
                ST_DRAIN: begin
                    if (r_drain == 2'd0) r_state <= ST_DONE;
                    else                 r_drain <= r_drain - 2'd1;
                end
                ST_DONE: begin
                    r_result <= mac_psum;
                    r_done   <= 1'b1;
                    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // The read strobe, delayed by memory plus MAC latency, marks the accumulate slot.
    pim_valid_delay #(
        .DEPTH (NEXT_DLY)
    ) u_next_dly (
        .clk     (clk),
        .i_flush (w_flush),
        .i_valid (w_issue),
        .o_valid (mac_next)
    );

    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;
    assign result    = r_result;
    assign rd_en_a   = w_issue;
    assign rd_en_b   = w_issue;
    assign rd_addr_a = r_addr_a;
    assign rd_addr_b = r_addr_b;
    assign mac_a     = rd_data_a;
    assign mac_b     = rd_data_b;
    assign mac_clear = (r_state == ST_CLEAR);

`ifdef PIM_DOT_OVF_EN
    logic [PSUM_W-1:0] r_psum_prev;
    logic              r_next_d;
    logic              r_ovf_sticky;
    logic              r_ovf;
    logic              w_wrap;

    // An unsigned accumulator can only decrease right after an add if it wrapped.
    assign w_wrap = r_next_d && (mac_psum < r_psum_prev);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_psum_prev  <= '0;
            r_next_d     <= 1'b0;
            r_ovf_sticky <= 1'b0;
            r_ovf        <= 1'b0;
        end else begin
            r_psum_prev <= mac_psum;
            r_next_d    <= mac_next;
            if (r_state == ST_CLEAR) r_ovf_sticky <= 1'b0;
            else if (w_wrap)         r_ovf_sticky <= 1'b1;
            if (r_state == ST_DONE)  r_ovf <= r_ovf_sticky | w_wrap;
            else if (w_zero_cmd)     r_ovf <= 1'b0;
        end
    end

    assign ovf = r_ovf;
`else
    logic w_unused;
    assign w_unused = w_zero_cmd;
`endif

endmodule

// File: tb/tb_pim_dot_sequencer.sv
// Scoreboard bench for pim_dot_sequencer with behavioural bank memories and MAC.
// Expected dot products come from plain arithmetic over the bench's memory arrays.
module tb_pim_dot_sequencer;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [7:0]   base_a = '0;
    logic [7:0]   base_b = '0;
    logic [8:0]   len = '0;
    logic         busy, done, rd_en_a, rd_en_b, mac_clear, mac_next;
    logic [64:0]  result;
    logic [7:0]   rd_addr_a, rd_addr_b;
    logic [31:0]  rd_data_a = '0, rd_data_b = '0;
    logic [31:0]  mac_a, mac_b;
    logic [64:0]  mac_psum = '0;
`ifdef PIM_DOT_OVF_EN
    logic         ovf;
`endif

    pim_dot_sequencer #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .base_a    (base_a),
        .base_b    (base_b),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .rd_en_a   (rd_en_a),
        .rd_en_b   (rd_en_b),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_clear (mac_clear),
        .mac_next  (mac_next),
        .mac_psum  (mac_psum)
`ifdef PIM_DOT_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Banks: synchronous read, one cycle latency.
    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    always @(posedge clk) begin
        if (rd_en_a) rd_data_a <= mem_a[rd_addr_a];
        if (rd_en_b) rd_data_b <= mem_b[rd_addr_b];
    end

    // MAC: operand register, product register, accumulate when next is high.
    logic [31:0] m_a1 = '0, m_b1 = '0;
    logic [64:0] m_prod = '0;
    always @(posedge clk) begin
        if (!reset_n) begin
            m_a1 <= '0; m_b1 <= '0; m_prod <= '0; mac_psum <= '0;
        end else begin
            m_a1   <= mac_a;
            m_b1   <= mac_b;
            m_prod <= 65'(m_a1) * 65'(m_b1);
            if (mac_clear)     mac_psum <= '0;
            else if (mac_next) mac_psum <= mac_psum + m_prod;
        end
    end

    typedef struct { int s; int n; logic [64:0] res; bit ovf; } exp_t;
    typedef struct { logic [7:0] a; logic [7:0] b; } addr_t;
    exp_t  sb_q[$];
    addr_t addr_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired or unexpected event at cycle %0d", name, cyc);
    endtask

    task automatic wait_not_busy();
        int k = 0;
        while (busy && k < 300) begin @(posedge clk); #1; k++; end
        if (busy) fail_now("wait_not_busy");
    endtask

    task automatic wait_all();
        int k = 0;
        while ((sb_q.size() != 0 || busy) && k < 500) begin @(posedge clk); #1; k++; end
        if (sb_q.size() != 0 || busy) fail_now("wait_all");
    endtask

    // Caller sits just after a rising edge; start is held for one cycle.
    task automatic issue(input int ba, input int bb, input int n, input bit track);
        exp_t        e;
        addr_t       ae;
        logic [127:0] acc;
        int          ia, ib;
        wait_not_busy();
        base_a = 8'(ba);
        base_b = 8'(bb);
        len    = 9'(n);
        start  = 1'b1;
        if (track) begin
            acc = '0;
            for (int i = 0; i < n; i++) begin
                ia = (ba + i) % 256;
                ib = (bb + i) % 256;
                acc = acc + 128'(mem_a[ia]) * 128'(mem_b[ib]);
                ae.a = ia[7:0];
                ae.b = ib[7:0];
                addr_q.push_back(ae);
            end
            e.s   = cyc;
            e.n   = n;
            e.res = acc[64:0];
            e.ovf = (acc[127:65] != '0);
            sb_q.push_back(e);
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic poke_while_busy(input int ba, input int bb, input int n);
        check("busy_at_ignored_start", busy, 1);
        base_a = 8'(ba); base_b = 8'(bb); len = 9'(n); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Monitor: per-command activity is collected and judged at each done pulse.
    bit mon_en = 1'b1;
    int first_rd = -1, first_nx = -1, clr_cyc = -1;
    int n_rd = 0, n_nx = 0, n_clr = 0;

    task automatic clear_mon();
        first_rd = -1; first_nx = -1; clr_cyc = -1;
        n_rd = 0; n_nx = 0; n_clr = 0;
    endtask

    always @(negedge clk) begin
        if (mon_en && reset_n) begin
            if (rd_en_a || rd_en_b) begin
                n_rd++;
                if (first_rd < 0) first_rd = cyc;
                if (addr_q.size() == 0) fail_now("rd_unexpected");
                else begin
                    addr_t ae;
                    ae = addr_q.pop_front();
                    check("rd_addr_a", rd_addr_a, ae.a);
                    check("rd_addr_b", rd_addr_b, ae.b);
                    check("rd_en_pair", {rd_en_a, rd_en_b}, 2'b11);
                end
            end
            if (mac_next) begin
                n_nx++;
                if (first_nx < 0) first_nx = cyc;
            end
            if (mac_clear) begin
                n_clr++;
                if (clr_cyc < 0) clr_cyc = cyc;
            end
            if (done) begin
                if (sb_q.size() == 0) fail_now("done_unexpected");
                else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("done_cycle", cyc, (e.n == 0) ? e.s + 1 : e.s + e.n + 6);
                    check("result", result, e.res);
                    check("busy_at_done", busy, 0);
                    check("rd_count", n_rd, e.n);
                    check("next_count", n_nx, e.n);
                    check("clear_count", n_clr, (e.n == 0) ? 0 : 1);
                    check("clear_cycle", clr_cyc, (e.n == 0) ? -1 : e.s + 1);
                    check("first_rd_cycle", first_rd, (e.n == 0) ? -1 : e.s + 2);
                    check("first_next_cycle", first_nx, (e.n == 0) ? -1 : e.s + 5);
`ifdef PIM_DOT_OVF_EN
                    check("ovf", ovf, e.ovf);
`endif
                    $display("txn start=%0d len=%0d result=%0h exp_ovf=%0b done@%0d",
                             e.s, e.n, result, e.ovf, cyc);
                end
                clear_mon();
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = $urandom;
            mem_b[i] = $urandom;
        end
        for (int i = 0; i < 4; i++) begin
            mem_a[i] = 32'(i + 1);
            mem_b[i] = 32'(i + 5);
        end
        mem_a[16] = 3; mem_a[17] = 3; mem_b[16] = 2; mem_b[17] = 2;
        for (int i = 32; i < 35; i++) begin
            mem_a[i] = 32'hFFFF_FFFF;
            mem_b[i] = 32'hFFFF_FFFF;
        end
        mem_a[40] = 7; mem_b[40] = 9;

        // Reset state
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_rd_en", {rd_en_a, rd_en_b}, 0);
        check("reset_mac_ctl", {mac_clear, mac_next}, 0);
        check("reset_addr", {rd_addr_a, rd_addr_b}, 0);
        check("reset_result", result, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Basic dot product
        issue(0, 0, 4, 1);
        wait_all();
        check("basic_70", result, 70);

        // Zero length
        issue(5, 5, 0, 1);
        wait_all();
        check("zero_len_result", result, 0);

        // Back-to-back: ignored start while busy, then start in the done cycle
        issue(0, 0, 4, 1);
        repeat (3) begin @(posedge clk); #1; end
        poke_while_busy(16, 16, 2);
        wait_not_busy();
        check("done_when_restart", done, 1);
        issue(16, 16, 2, 1);
        wait_all();
        check("b2b_12", result, 12);

        // Address wrap
        issue(254, 0, 4, 1);
        wait_all();

        // Overflow
        issue(32, 32, 3, 1);
        wait_all();
        check("ovf_result", result, 65'h0_FFFF_FFFA_0000_0003);
`ifdef PIM_DOT_OVF_EN
        check("ovf_flag", ovf, 1);
`endif

        // Reset in the second ISSUE cycle
        mon_en = 1'b0;
        issue(0, 0, 4, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("issue_before_reset", rd_en_a, 1);
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_rd_en", {rd_en_a, rd_en_b}, 0);
        check("midrst_mac_ctl", {mac_clear, mac_next}, 0);
        check("midrst_addr", {rd_addr_a, rd_addr_b}, 0);
        check("midrst_result", result, 0);
        reset_n = 1'b1;
        addr_q.delete();
        sb_q.delete();
        clear_mon();
        mon_en = 1'b1;
        @(posedge clk); #1;
        issue(40, 40, 1, 1);
        wait_all();
        check("post_reset_63", result, 63);

        // Randomised commands, often back-to-back
        for (int t = 0; t < 12; t++) begin
            issue($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 20), 1);
            if ($urandom_range(0, 1) == 0) wait_all();
        end
        wait_all();
        repeat (5) begin @(posedge clk); #1; end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
